// File: rtl/interrupt_request_controller.sv
// Four-source interrupt controller: two groups of two sources, mask/pending registers,
// per-group IDLE/REQUEST/SERVICE handshake with the CPU, group 0 may nest over group 1.
module interrupt_request_controller #(
  parameter logic [3:0] RESET_MASK = 4'h0,
  parameter logic [3:0] EDGE_MODE  = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_in,
  input  logic        commit,
  input  logic        ack0,
  input  logic        ack1,
  input  logic        retix,
  input  logic        mask_wr,
  input  logic        pend_clr,
  input  logic [15:0] data_in,
  output logic        int0,
  output logic        int1,
  output logic [1:0]  vector,
  output logic [3:0]  pending,
  output logic [3:0]  mask,
  output logic [1:0]  in_service
);

  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} grp_state_t;

  grp_state_t state0, state1;
  logic [3:0] irq_prev;
  logic [3:0] enabled, edge_trig, level_trig, ack_clr, sw_clr, pending_nxt;
  logic [1:0] src0, src1;
  logic       req0, req1, ack0_ok, ack1_ok, ret0, ret1;

  // NOTE: every variable gets a default at the top of the block so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    enabled  = pending & mask;
    req0     = |enabled[1:0];
    req1     = |enabled[3:2];
    src0     = enabled[0] ? 2'd0 : 2'd1;
    src1     = enabled[2] ? 2'd2 : 2'd3;
    ack0_ok  = ack0 && commit && (state0 == REQUEST) && req0;
    ack1_ok  = ack1 && commit && (state1 == REQUEST) && req1;
    ret0     = retix && commit && in_service[0];
    ret1     = retix && commit && !in_service[0] && in_service[1];
    ack_clr  = '0;
    if (ack0_ok) ack_clr[src0] = 1'b1;
    if (ack1_ok) ack_clr[src1] = 1'b1;
    sw_clr   = pend_clr ? data_in[3:0] : 4'h0;
    edge_trig  = EDGE_MODE & irq_in & ~irq_prev;
    // A level source's ACK clear is visible for one cycle before it re-pends.
    level_trig = ~EDGE_MODE & irq_in & ~ack_clr;
    pending_nxt = (pending & ~(ack_clr | sw_clr)) | edge_trig | level_trig;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev   <= '0;
      pending    <= '0;
      mask       <= RESET_MASK;
      vector     <= '0;
      in_service <= '0;
      state0     <= IDLE;
      state1     <= IDLE;
      int0       <= 1'b0;
      int1       <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      pending  <= pending_nxt;
      if (mask_wr) mask <= data_in[3:0];
      if (ack0_ok)      vector <= src0;
      else if (ack1_ok) vector <= src1;

      case (state0)
        IDLE: if (req0) begin
          state0 <= REQUEST;
          int0   <= 1'b1;
        end
        REQUEST: if (ack0_ok) begin
          state0        <= SERVICE;
          int0          <= 1'b0;
          in_service[0] <= 1'b1;
        end else if (!req0) begin
          state0 <= IDLE;
          int0   <= 1'b0;
        end
        SERVICE: if (ret0) begin
          state0        <= IDLE;
          in_service[0] <= 1'b0;
        end
        default: begin
          state0 <= IDLE;
          int0   <= 1'b0;
        end
      endcase

      // Group 1 may not start a request while group 0 is being serviced.
      case (state1)
        IDLE: if (req1 && !in_service[0]) begin
          state1 <= REQUEST;
          int1   <= 1'b1;
        end
        REQUEST: if (ack1_ok) begin
          state1        <= SERVICE;
          int1          <= 1'b0;
          in_service[1] <= 1'b1;
        end else if (!req1) begin
          state1 <= IDLE;
          int1   <= 1'b0;
        end
        SERVICE: if (ret1) begin
          state1        <= IDLE;
          in_service[1] <= 1'b0;
        end
        default: begin
          state1 <= IDLE;
          int1   <= 1'b0;
        end
      endcase
    end
  end

endmodule
